// File: rtl/axis_switch_pkg.sv
// Shared types and helpers for the AXI-Stream switch family.
package axis_switch_pkg;

    localparam int NUM_INPUTS = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Round-robin pick between two requesters: a lone requester wins,
    // a tie goes to whoever did not win last time.
    function automatic logic rr_pick(input logic [NUM_INPUTS-1:0] valid,
                                     input logic                  last_grant);
        logic pick;
        if (valid == 2'b11) begin
            pick = !last_grant;
        end else if (valid[1]) begin
            pick = 1'b1;
        end else if (valid[0]) begin
            pick = 1'b0;
        end else begin
            pick = last_grant;
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage AXI-Stream register: accepts a new beat whenever the stage
// is empty or its current beat is being taken downstream.
module axis_reg_slice
    import axis_switch_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_payload,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_payload,
    output logic             out_valid,
    input  logic             out_ready
);

    assign in_ready = !out_valid || out_ready;

    // Load payload and valid together whenever the stage can take a new beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_payload <= '0;
            out_valid   <= 1'b0;
        end else if (in_ready) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            out_payload <= in_payload;
            out_valid   <= in_valid;
        end
    end

endmodule

// File: rtl/axi_stream_2_to_1_switch.sv
// Two-input AXI-Stream merge with packet-granular round-robin arbitration
// and a registered output stage.
module axi_stream_2_to_1_switch
    import axis_switch_pkg::*;
#(
    parameter int AXIS_BUS_WIDTH      = 64,
    parameter int AXIS_TID_WIDTH      = 1,
    parameter int AXIS_TDEST_WIDTH    = 1,
    parameter int AXIS_TUSER_WIDTH    = 1,
    parameter int FIRST_PRIORITY      = 0,
    parameter int ENABLE_SECURE_INPUT = 1
) (
    input  logic                          aclk,
    input  logic                          aresetn,

    input  logic [AXIS_BUS_WIDTH-1:0]     axis_in_0_tdata,
    input  logic [AXIS_BUS_WIDTH/8-1:0]   axis_in_0_tkeep,
    input  logic [AXIS_TID_WIDTH-1:0]     axis_in_0_tid,
    input  logic [AXIS_TDEST_WIDTH-1:0]   axis_in_0_tdest,
    input  logic [AXIS_TUSER_WIDTH-1:0]   axis_in_0_tuser,
    input  logic                          axis_in_0_tlast,
    input  logic                          axis_in_0_tvalid,
    output logic                          axis_in_0_tready,

    input  logic [AXIS_BUS_WIDTH-1:0]     axis_in_1_tdata,
    input  logic [AXIS_BUS_WIDTH/8-1:0]   axis_in_1_tkeep,
    input  logic [AXIS_TID_WIDTH-1:0]     axis_in_1_tid,
    input  logic [AXIS_TDEST_WIDTH-1:0]   axis_in_1_tdest,
    input  logic [AXIS_TUSER_WIDTH-1:0]   axis_in_1_tuser,
    input  logic                          axis_in_1_tlast,
    input  logic                          axis_in_1_tvalid,
    output logic                          axis_in_1_tready,

    output logic [AXIS_BUS_WIDTH-1:0]     axis_out_tdata,
    output logic [AXIS_BUS_WIDTH/8-1:0]   axis_out_tkeep,
    output logic [AXIS_TID_WIDTH-1:0]     axis_out_tid,
    output logic [AXIS_TDEST_WIDTH-1:0]   axis_out_tdest,
    output logic [AXIS_TUSER_WIDTH-1:0]   axis_out_tuser,
    output logic                          axis_out_tlast,
    output logic                          axis_out_tvalid,
    input  logic                          axis_out_tready
);

    localparam int   KEEP_WIDTH       = AXIS_BUS_WIDTH / 8;
    localparam int   PAYLOAD_WIDTH    = AXIS_BUS_WIDTH + KEEP_WIDTH + AXIS_TID_WIDTH +
                                        AXIS_TDEST_WIDTH + AXIS_TUSER_WIDTH + 1;
    localparam logic RESET_LAST_GRANT = (FIRST_PRIORITY == 0);

    arb_state_t               state;
    logic                     grant;
    logic                     last_grant;
    logic                     next_grant;
    logic                     busy;
    logic [NUM_INPUTS-1:0]    in_valid;
    logic [PAYLOAD_WIDTH-1:0] payload_0;
    logic [PAYLOAD_WIDTH-1:0] payload_1;
    logic [PAYLOAD_WIDTH-1:0] slice_payload;
    logic [PAYLOAD_WIDTH-1:0] out_payload;
    logic                     slice_valid;
    logic                     granted_last;
    logic                     out_load;

    // Payload layout is {tdata, tkeep, tid, tdest, tuser, tlast}.
    assign payload_0 = {axis_in_0_tdata, axis_in_0_tkeep, axis_in_0_tid,
                        axis_in_0_tdest, axis_in_0_tuser, axis_in_0_tlast};
    assign payload_1 = {axis_in_1_tdata, axis_in_1_tkeep, axis_in_1_tid,
                        axis_in_1_tdest, axis_in_1_tuser, axis_in_1_tlast};

    assign in_valid   = {axis_in_1_tvalid, axis_in_0_tvalid};
    assign busy       = (state == BUSY);
    assign next_grant = rr_pick(in_valid, last_grant);

    // Steer the granted input into the output stage and gate the readies.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        slice_payload    = grant ? payload_1 : payload_0;
        slice_valid      = 1'b0;
        granted_last     = grant ? axis_in_1_tlast : axis_in_0_tlast;
        axis_in_0_tready = 1'b0;
        axis_in_1_tready = 1'b0;

        if (busy) begin
            slice_valid      = grant ? axis_in_1_tvalid : axis_in_0_tvalid;
            axis_in_0_tready = !grant && out_load;
            axis_in_1_tready =  grant && out_load;
        end else if (ENABLE_SECURE_INPUT != 0) begin
            // With no grant, nothing from either input may reach the output.
            slice_payload = '0;
        end
    end

    // Arbiter: pick an input in IDLE, hold it until its tlast beat is taken.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            grant      <= RESET_LAST_GRANT;
            last_grant <= RESET_LAST_GRANT;
        end else begin
            case (state)
                IDLE: begin
                    if (|in_valid) begin
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (slice_valid && out_load && granted_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    axis_reg_slice #(
        .WIDTH (PAYLOAD_WIDTH)
    ) u_out_slice (
        .clk         (aclk),
        .rst_n       (aresetn),
        .in_payload  (slice_payload),
        .in_valid    (slice_valid),
        .in_ready    (out_load),
        .out_payload (out_payload),
        .out_valid   (axis_out_tvalid),
        .out_ready   (axis_out_tready)
    );

    assign {axis_out_tdata, axis_out_tkeep, axis_out_tid,
            axis_out_tdest, axis_out_tuser, axis_out_tlast} = out_payload;

endmodule

// File: tb/tb_axi_stream_2_to_1_switch.sv
// Directed bench for the 2-to-1 AXI-Stream switch: a beat scoreboard plus
// packet-ownership and backpressure rules checked every cycle, and
// hand-computed timing expectations per scenario.
module tb_axi_stream_2_to_1_switch;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        id;
        logic        dest;
        logic        user;
        logic        last;
    } beat_t;

    logic        aclk;
    logic        aresetn;
    logic [63:0] in_tdata  [2];
    logic [7:0]  in_tkeep  [2];
    logic        in_tid    [2];
    logic        in_tdest  [2];
    logic        in_tuser  [2];
    logic        in_tlast  [2];
    logic        in_tvalid [2];
    logic        in_tready [2];
    logic [63:0] out_tdata;
    logic [7:0]  out_tkeep;
    logic        out_tid;
    logic        out_tdest;
    logic        out_tuser;
    logic        out_tlast;
    logic        out_tvalid;
    logic        out_tready;

    int    vectors;
    int    miscompares;
    beat_t exp_q[$];

    axi_stream_2_to_1_switch dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .axis_in_0_tdata  (in_tdata[0]),
        .axis_in_0_tkeep  (in_tkeep[0]),
        .axis_in_0_tid    (in_tid[0]),
        .axis_in_0_tdest  (in_tdest[0]),
        .axis_in_0_tuser  (in_tuser[0]),
        .axis_in_0_tlast  (in_tlast[0]),
        .axis_in_0_tvalid (in_tvalid[0]),
        .axis_in_0_tready (in_tready[0]),
        .axis_in_1_tdata  (in_tdata[1]),
        .axis_in_1_tkeep  (in_tkeep[1]),
        .axis_in_1_tid    (in_tid[1]),
        .axis_in_1_tdest  (in_tdest[1]),
        .axis_in_1_tuser  (in_tuser[1]),
        .axis_in_1_tlast  (in_tlast[1]),
        .axis_in_1_tvalid (in_tvalid[1]),
        .axis_in_1_tready (in_tready[1]),
        .axis_out_tdata   (out_tdata),
        .axis_out_tkeep   (out_tkeep),
        .axis_out_tid     (out_tid),
        .axis_out_tdest   (out_tdest),
        .axis_out_tuser   (out_tuser),
        .axis_out_tlast   (out_tlast),
        .axis_out_tvalid  (out_tvalid),
        .axis_out_tready  (out_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Beat i of an n-beat packet: data counts up from base, the last beat
    // carries a partial keep, sideband bits come from sb = {user, dest, id}.
    function automatic beat_t make_beat(input logic [63:0] base, input int i, input int n,
                                        input logic [2:0] sb);
        beat_t b;
        b.data = base + 64'(i);
        b.last = (i == n - 1);
        b.keep = b.last ? 8'h0F : 8'hFF;
        b.id   = sb[0];
        b.dest = sb[1];
        b.user = sb[2];
        return b;
    endfunction

    task automatic expect_pkt(input int n, input logic [63:0] base, input logic [2:0] sb);
        for (int i = 0; i < n; i++) exp_q.push_back(make_beat(base, i, n, sb));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Drive one packet on input p; optionally drop tvalid for 2 cycles after
    // beat gap_after. Aborts quietly if reset is asserted.
    task automatic drive_pkt(input int p, input int n, input logic [63:0] base,
                             input logic [2:0] sb, input int gap_after);
        beat_t b;
        bit    hs;
        int    budget;
        for (int i = 0; i < n; i++) begin
            b            = make_beat(base, i, n, sb);
            in_tdata[p]  = b.data;
            in_tkeep[p]  = b.keep;
            in_tid[p]    = b.id;
            in_tdest[p]  = b.dest;
            in_tuser[p]  = b.user;
            in_tlast[p]  = b.last;
            in_tvalid[p] = 1'b1;
            hs           = 1'b0;
            budget       = 0;
            while (!hs) begin
                @(negedge aclk);
                hs = in_tvalid[p] && in_tready[p];
                @(posedge aclk);
                #1;
                if (!aresetn) begin
                    in_tvalid[p] = 1'b0;
                    return;
                end
                budget++;
                if (!hs && budget > 200) begin
                    check($sformatf("drive_timeout_in%0d", p), 0, 1);
                    in_tvalid[p] = 1'b0;
                    return;
                end
            end
            if (i == gap_after) begin
                in_tvalid[p] = 1'b0;
                step(2);
            end
        end
        in_tvalid[p] = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            step(1);
            cyc++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Per-cycle compare process: output beats against the expected order,
    // packet ownership of the inputs, and output hold under backpressure.
    int          owner;
    bit          bp_prev;
    beat_t       bp_snap;
    always @(negedge aclk) begin
        beat_t got;
        bit    hs0;
        bit    hs1;
        got = {out_tdata, out_tkeep, out_tid, out_tdest, out_tuser, out_tlast};
        if (!aresetn) begin
            owner   = -1;
            bp_prev = 1'b0;
        end else begin
            if (out_tvalid && out_tready) begin
                if (exp_q.size() == 0) check("unexpected_out_beat", got, 0);
                else                   check("out_beat", got, exp_q.pop_front());
            end
            if (bp_prev) check("bp_hold", {out_tvalid, got}, {1'b1, bp_snap});
            if (out_tvalid && !out_tready)
                check("bp_readys_low", {in_tready[1], in_tready[0]}, 2'b00);
            bp_prev = out_tvalid && !out_tready;
            bp_snap = got;

            hs0 = in_tvalid[0] && in_tready[0];
            hs1 = in_tvalid[1] && in_tready[1];
            if (owner >= 0) check("other_ready_low", in_tready[1 - owner], 0);
            if (hs0) begin
                if (owner >= 0) check("owner_in0", owner, 0);
                owner = in_tlast[0] ? -1 : 0;
            end
            if (hs1) begin
                if (owner >= 0) check("owner_in1", owner, 1);
                owner = in_tlast[1] ? -1 : 1;
            end
        end
    end

    int          lat;
    bit          seen;
    logic [64:0] trace [8];
    bit          t2_valid [8] = '{0, 1, 1, 0, 1, 1, 0, 1};
    logic [63:0] t2_data  [8] = '{64'h0, 64'h100, 64'h101, 64'h0,
                                  64'h200, 64'h201, 64'h0, 64'h110};
    logic [2:0]  t6_sb    [4] = '{3'b111, 3'b010, 3'b101, 3'b000};
    int          beat_cyc[$];

    initial begin
        vectors     = 0;
        miscompares = 0;
        owner       = -1;
        bp_prev     = 1'b0;
        for (int p = 0; p < 2; p++) begin
            in_tdata[p]  = '0;
            in_tkeep[p]  = '0;
            in_tid[p]    = 1'b0;
            in_tdest[p]  = 1'b0;
            in_tuser[p]  = 1'b0;
            in_tlast[p]  = 1'b0;
            in_tvalid[p] = 1'b0;
        end
        out_tready = 1'b1;
        aresetn    = 1'b0;

        // Reset state
        step(3);
        check("rst_out_valid", out_tvalid, 0);
        check("rst_out_fields", {out_tdata, out_tkeep, out_tid, out_tdest, out_tuser, out_tlast}, 0);
        check("rst_readys", {in_tready[1], in_tready[0]}, 2'b00);
        aresetn = 1'b1;
        step(1);

        // Input 0 only, 3-beat packet: first beat 2 cycles after tvalid.
        expect_pkt(3, 64'hA0, 3'b101);
        fork
            drive_pkt(0, 3, 64'hA0, 3'b101, -1);
            begin
                lat  = 0;
                seen = 1'b0;
                for (int k = 1; k <= 10 && !seen; k++) begin
                    step(1);
                    if (out_tvalid) begin
                        seen = 1'b1;
                        lat  = k;
                    end
                end
                check("t1_latency", lat, 2);
                check("t1_beat0", {out_tvalid, out_tkeep, out_tdata}, {1'b1, 8'hFF, 64'hA0});
                step(1);
                check("t1_beat1", {out_tvalid, out_tlast, out_tdata}, {2'b10, 64'hA1});
                step(1);
                check("t1_beat2", {out_tvalid, out_tlast, out_tkeep, out_tdata},
                      {2'b11, 8'h0F, 64'hA2});
            end
        join
        drain();
        step(2);

        // Both inputs valid right after reset: order 0,1,0,1 with bubbles.
        aresetn = 1'b0;
        step(1);
        aresetn = 1'b1;
        step(1);
        expect_pkt(2, 64'h100, 3'b001);
        expect_pkt(2, 64'h200, 3'b010);
        expect_pkt(2, 64'h110, 3'b011);
        expect_pkt(2, 64'h210, 3'b100);
        fork
            begin
                drive_pkt(0, 2, 64'h100, 3'b001, -1);
                drive_pkt(0, 2, 64'h110, 3'b011, -1);
            end
            begin
                drive_pkt(1, 2, 64'h200, 3'b010, -1);
                drive_pkt(1, 2, 64'h210, 3'b100, -1);
            end
            for (int k = 0; k < 8; k++) begin
                step(1);
                trace[k] = {out_tvalid, out_tdata};
            end
        join
        for (int k = 0; k < 8; k++)
            check($sformatf("t2_trace_cycle%0d", k + 1), trace[k], {t2_valid[k], t2_data[k]});
        drain();
        step(2);

        // Interleave attempt: input 1 raises tvalid during beat 2 of input 0.
        expect_pkt(4, 64'h300, 3'b110);
        expect_pkt(2, 64'h400, 3'b001);
        fork
            drive_pkt(0, 4, 64'h300, 3'b110, -1);
            begin
                step(3);
                drive_pkt(1, 2, 64'h400, 3'b001, -1);
            end
        join
        drain();
        step(2);

        // Backpressure for 5 cycles mid-packet on input 1.
        expect_pkt(5, 64'h500, 3'b111);
        fork
            drive_pkt(1, 5, 64'h500, 3'b111, -1);
            begin
                step(4);
                out_tready = 1'b0;
                step(5);
                check("t4_held_beat", {out_tvalid, out_tdata}, {1'b1, 64'h502});
                check("t4_granted_ready", in_tready[1], 0);
                out_tready = 1'b1;
            end
        join
        drain();
        step(2);

        // Input tvalid dropping mid-packet: grant is held, nothing lost.
        expect_pkt(4, 64'hB00, 3'b011);
        fork
            drive_pkt(0, 4, 64'hB00, 3'b011, 1);
            begin
                step(4);
                drive_pkt(1, 1, 64'hC00, 3'b100, -1);
            end
        join
        expect_pkt(1, 64'hC00, 3'b100);
        drain();
        step(2);

        // Async reset between clock edges, mid-packet.
        expect_pkt(6, 64'h600, 3'b000);
        fork
            drive_pkt(0, 6, 64'h600, 3'b000, -1);
            begin
                seen = 1'b0;
                for (int k = 0; k < 10 && !seen; k++) begin
                    step(1);
                    if (out_tvalid) seen = 1'b1;
                end
                #3;
                aresetn = 1'b0;
                #1;
                check("t5_async_valid", out_tvalid, 0);
                check("t5_async_data", out_tdata, 0);
                check("t5_async_readys", {in_tready[1], in_tready[0]}, 2'b00);
            end
        join
        exp_q.delete();
        step(1);
        aresetn = 1'b1;
        step(1);
        expect_pkt(2, 64'h700, 3'b010);
        expect_pkt(2, 64'h800, 3'b101);
        fork
            drive_pkt(0, 2, 64'h700, 3'b010, -1);
            drive_pkt(1, 2, 64'h800, 3'b101, -1);
            begin
                lat  = 0;
                seen = 1'b0;
                for (int k = 1; k <= 10 && !seen; k++) begin
                    step(1);
                    if (out_tvalid) begin
                        seen = 1'b1;
                        lat  = k;
                    end
                end
                check("t5_rearb_latency", lat, 2);
                check("t5_rearb_first", out_tdata, 64'h700);
            end
        join
        drain();
        step(2);

        // Single-beat packets back-to-back on input 1: one beat per 2 cycles.
        for (int j = 0; j < 4; j++) expect_pkt(1, 64'h900 + 64'(j), t6_sb[j]);
        fork
            for (int j = 0; j < 4; j++) drive_pkt(1, 1, 64'h900 + 64'(j), t6_sb[j], -1);
            for (int k = 1; k <= 10; k++) begin
                step(1);
                if (out_tvalid) beat_cyc.push_back(k);
            end
        join
        check("t6_beat_count", beat_cyc.size(), 4);
        for (int j = 0; j < beat_cyc.size() && j < 4; j++)
            check($sformatf("t6_beat%0d_cycle", j), beat_cyc[j], 2 * (j + 1));
        drain();
        step(2);

        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
